mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the CPU's HI/LO path, sitting directly downstream of the register file. It latches the two register-file read operands (rs, rt) on a start request and runs MULT, MULTU, DIV or DIVU over 33 clock cycles, ending with the 64-bit result in HI/LO. It raises Busy so the control unit can stall the PC. It also services MTHI/MTLO writes; HI and LO are exposed continuously for MFHI/MFLO.

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Start/operand/MTHI-MTLO request bus and HI/LO result bus between the CPU
// control path and mult_div_unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MdOp;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             WriteHi;
  logic             WriteLo;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MdOp, ReadData1, ReadData2, WriteHi, WriteLo, WriteData,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, MdOp, ReadData1, ReadData2, WriteHi, WriteLo, WriteData,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, signs handled on magnitudes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            CLK,
  input logic            Reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     rawA_q, rawA_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
  logic                 divZero_q, divZero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signA, signB;
  logic [WIDTH-1:0]     magA, magB;
  logic [WIDTH:0]       sum, trial, diff;
  logic [2*WIDTH-1:0]   fixProd;

  // MdOp[0] marks the unsigned variants, so their sign bits are ignored.
  assign signA = bus.ReadData1[WIDTH-1] & ~bus.MdOp[0];
  assign signB = bus.ReadData2[WIDTH-1] & ~bus.MdOp[0];
  assign magA  = signA ? -bus.ReadData1 : bus.ReadData1;
  assign magB  = signB ? -bus.ReadData2 : bus.ReadData2;

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = (state_q != IDLE);
  end

  // Multiply keeps the multiplicand in opnd and the multiplier in acc's low half;
  // divide keeps the divisor in opnd and {remainder, quotient} in acc.
  always_comb begin
    op_d      = op_q;
    opnd_d    = opnd_q;
    rawA_d    = rawA_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    trial     = '0;
    diff      = '0;
    fixProd   = '0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          op_d      = bus.MdOp;
          rawA_d    = bus.ReadData1;
          negRes_d  = signA ^ signB;
          negRem_d  = signA;
          divZero_d = (bus.ReadData2 == '0);
          cnt_d     = '0;
          if (bus.MdOp[1]) begin
            opnd_d = magB;
            acc_d  = {{WIDTH{1'b0}}, magA};
          end else begin
            opnd_d = magA;
            acc_d  = {{WIDTH{1'b0}}, magB};
          end
        end else begin
          if (bus.WriteHi) hi_d = bus.WriteData;
          if (bus.WriteLo) lo_d = bus.WriteData;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          diff  = trial - {1'b0, opnd_q};
          // The partial remainder stays below the divisor, so diff's top bit is a clean borrow.
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (!op_q[1]) begin
          fixProd = negRes_q ? -acc_q : acc_q;
          hi_d    = fixProd[2*WIDTH-1:WIDTH];
          lo_d    = fixProd[WIDTH-1:0];
        end else if (divZero_q) begin
          lo_d = '1;
          hi_d = rawA_q;
        end else begin
          lo_d = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      op_q      <= '0;
      opnd_q    <= '0;
      rawA_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      rawA_q    <= rawA_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed and random MULT/DIV operations checked
// against a plain-arithmetic HI/LO model, plus reset abort and MTHI/MTLO cases.
module tb_mult_div_unit;
  logic clk;
  logic resetN;
  int   asserts;
  int   failures;
  logic [31:0] expHi;
  logic [31:0] expLo;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK   (clk),
    .Reset (resetN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result as {HI, LO}, straight from signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, r, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    q = '0;
    r = '0;
    if (op == 2'b00)      res = 64'(sa * sb);
    else if (op == 2'b01) res = 64'(ua * ub);
    else if (b == 32'd0)  res = {a, 32'hFFFF_FFFF};
    else begin
      if (op == 2'b10) begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    asserts++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts one operation from IDLE (called at a negedge) and follows it to completion.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit pokeBusy, input bit writeLoAtStart);
    logic [63:0] ref64;
    int          busyCycles;
    ref64 = refModel(op, a, b);
    bus.Start     = 1'b1;
    bus.MdOp      = op;
    bus.ReadData1 = a;
    bus.ReadData2 = b;
    bus.WriteLo   = writeLoAtStart;
    bus.WriteData = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.Start     = 1'b0;
    bus.WriteLo   = 1'b0;
    bus.ReadData1 = $urandom;
    bus.ReadData2 = $urandom;
    bus.MdOp      = 2'($urandom);
    busyCycles = 0;
    while (bus.Busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      if (busyCycles == 16) begin
        checkOutput({tag, "_holdHi"}, {32'd0, bus.Hi}, {32'd0, expHi});
        checkOutput({tag, "_holdLo"}, {32'd0, bus.Lo}, {32'd0, expLo});
      end
      if (pokeBusy && busyCycles == 5) begin
        bus.Start     = 1'b1;
        bus.WriteHi   = 1'b1;
        bus.WriteData = 32'h0000_1234;
      end else begin
        bus.Start   = 1'b0;
        bus.WriteHi = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start   = 1'b0;
    bus.WriteHi = 1'b0;
    checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'd33);
    checkOutput({tag, "_done"}, {63'd0, bus.Done}, 64'd1);
    checkOutput({tag, "_hi"}, {32'd0, bus.Hi}, {32'd0, ref64[63:32]});
    checkOutput({tag, "_lo"}, {32'd0, bus.Lo}, {32'd0, ref64[31:0]});
    expHi = ref64[63:32];
    expLo = ref64[31:0];
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, {63'd0, bus.Done}, 64'd0);
    checkOutput({tag, "_idleBusy"}, {63'd0, bus.Busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA, rB;
    asserts       = 0;
    failures      = 0;
    expHi         = '0;
    expLo         = '0;
    resetN        = 1'b0;
    bus.Start     = 1'b0;
    bus.MdOp      = 2'b00;
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    bus.WriteHi   = 1'b0;
    bus.WriteLo   = 1'b0;
    bus.WriteData = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", {32'd0, bus.Hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, bus.Lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.Busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus.Done}, 64'd0);
    resetN = 1'b1;
    @(negedge clk);

    applyStimulus("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    checkOutput("mult_neg3x5_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    checkOutput("div_neg7by2_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("div_minby_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("div_minby_neg1_const", {bus.Hi, bus.Lo}, 64'h0000_0000_8000_0000);
    applyStimulus("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    applyStimulus("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

    // Abort an operation with reset on its 10th RUN cycle.
    bus.Start     = 1'b1;
    bus.MdOp      = 2'b01;
    bus.ReadData1 = $urandom;
    bus.ReadData2 = $urandom;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkOutput("abort_busy", {63'd0, bus.Busy}, 64'd0);
    checkOutput("abort_hi", {32'd0, bus.Hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, bus.Lo}, 64'd0);
    expHi = '0;
    expLo = '0;
    for (int i = 0; i < 30; i++) begin
      checkOutput("abort_noDone", {63'd0, bus.Done}, 64'd0);
      @(negedge clk);
    end
    applyStimulus("multu_6x7", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0);

    applyStimulus("divu_poked", 2'b11, 32'd1000, 32'd7, 1'b1, 1'b0);
    bus.WriteHi   = 1'b1;
    bus.WriteData = 32'h0000_1234;
    @(negedge clk);
    bus.WriteHi = 1'b0;
    checkOutput("mthi_hi", {32'd0, bus.Hi}, 64'h1234);
    checkOutput("mthi_lo", {32'd0, bus.Lo}, {32'd0, expLo});
    expHi = 32'h0000_1234;
    applyStimulus("start_wins", 2'b00, 32'hFFFF_FFF0, 32'h0000_0300, 1'b0, 1'b1);

    bus.WriteHi   = 1'b1;
    bus.WriteLo   = 1'b1;
    bus.WriteData = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.WriteHi = 1'b0;
    bus.WriteLo = 1'b0;
    checkOutput("mthilo_hi", {32'd0, bus.Hi}, 64'hA5A5_5A5A);
    checkOutput("mthilo_lo", {32'd0, bus.Lo}, 64'hA5A5_5A5A);
    expHi = 32'hA5A5_5A5A;
    expLo = 32'hA5A5_5A5A;

    for (int i = 0; i < 10; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      case ($urandom_range(0, 4))
        0:       rB = 32'd0;
        1:       rB = $urandom_range(1, 20);
        2:       rB = -($urandom_range(1, 20));
        default: rB = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d_op%0d", i, rOp), rOp, rA, rB, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
